control_unit: RTL and testbench

Multicycle finite-state controller for the processor datapath. It consumes the decoded fields of the instruction register and the ALU flags, then drives every write enable, mux select and ALU operation code of the datapath, one state per cycle. It sits directly upstream of the datapath top and is instantiated beside it, with its outputs wired to the datapath control wires.

---
 rtl/control_pkg.sv | 184 ++++++++++++++++++
 rtl/control_decoder.sv | 56 +++++
 rtl/control_unit.sv | 148 ++++++++++++++
 tb/tb_control_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg
//   Shared definitions for the multicycle controller: FSM state encoding,
//   opcode/funct constants, ALU_Control encodings, datapath mux select
//   encodings and the bundle of registered control outputs.
//   Build option: define CONTROL_UNIT_EXCEPTIONS_EN to add the EXC state
//   and the EPCWrite control.
package control_pkg;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type function codes (instruction bits [5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  // ALU_Control encodings
  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] ALU_AND    = 3'b011;
  localparam logic [2:0] ALU_CMP    = 3'b111;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSource encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
`ifdef CONTROL_UNIT_EXCEPTIONS_EN
  localparam logic [1:0] PCSRC_EXC    = 2'b10;
`endif
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  // RegDst / DataSrc encodings
  localparam logic [1:0] REGDST_RT      = 2'b00;
  localparam logic [1:0] REGDST_RD      = 2'b01;
  localparam logic [1:0] DATASRC_ALUOUT = 2'b00;
  localparam logic [1:0] DATASRC_MEM    = 2'b01;

  typedef enum logic [3:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_WB_R,
    ST_WB_I,
    ST_ADDR,
    ST_MEM_RD,
    ST_WB_LW,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JUMP
`ifdef CONTROL_UNIT_EXCEPTIONS_EN
    , ST_EXC
`endif
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_INVALID
  } instr_class_e;

  typedef struct packed {
    logic       pc_write;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       ab_write;
    logic       alu_out_write;
`ifdef CONTROL_UNIT_EXCEPTIONS_EN
    logic       epc_write;
`endif
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] reg_dst;
    logic [1:0] data_src;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  // Moore output decode for one state. fetch_last marks the final FETCH
  // cycle; r_op is the ALU op picked from FUNCT for EXEC_R. PCWrite in
  // BRANCH depends on EQ and is added outside this function.
  function automatic ctrl_t ctrl_for(input state_e st, input logic fetch_last,
                                     input logic [2:0] r_op);
    ctrl_t c;
    c = '0;
    // Idle selects sit at their all-zero encodings so RST drives all zeros.
    c.alu_src_b = SRCB_B;
    c.pc_source = PCSRC_ALU;
    c.reg_dst   = REGDST_RT;
    c.data_src  = DATASRC_ALUOUT;
    c.alu_ctrl  = ALU_PASS_A;
    case (st)
      ST_FETCH: begin
        c.alu_src_b = SRCB_FOUR;
        c.alu_ctrl  = ALU_ADD;
        if (fetch_last) begin
          c.ir_write  = 1'b1;
          c.pc_write  = 1'b1;
          c.pc_source = PCSRC_ALU;
        end
      end
      ST_DECODE: begin
        c.ab_write      = 1'b1;
        c.alu_out_write = 1'b1;
        c.alu_src_b     = SRCB_IMM_SH2;
        c.alu_ctrl      = ALU_ADD;
      end
      ST_EXEC_R: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_ctrl      = r_op;
        c.alu_out_write = 1'b1;
      end
      ST_EXEC_I, ST_ADDR: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_IMM;
        c.alu_ctrl      = ALU_ADD;
        c.alu_out_write = 1'b1;
      end
      ST_WB_R: begin
        c.reg_write = 1'b1;
        c.reg_dst   = REGDST_RD;
        c.data_src  = DATASRC_ALUOUT;
      end
      ST_WB_I: begin
        c.reg_write = 1'b1;
        c.reg_dst   = REGDST_RT;
        c.data_src  = DATASRC_ALUOUT;
      end
      ST_MEM_RD: c.iord = 1'b1;
      ST_WB_LW: begin
        c.reg_write = 1'b1;
        c.reg_dst   = REGDST_RT;
        c.data_src  = DATASRC_MEM;
      end
      ST_MEM_WR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_ctrl  = ALU_CMP;
        c.pc_source = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        c.pc_source = PCSRC_JUMP;
        c.pc_write  = 1'b1;
      end
`ifdef CONTROL_UNIT_EXCEPTIONS_EN
      ST_EXC: begin
        c.alu_src_b = SRCB_FOUR;
        c.alu_ctrl  = ALU_SUB;
        c.epc_write = 1'b1;
        c.pc_source = PCSRC_EXC;
        c.pc_write  = 1'b1;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_decoder.sv
// control_decoder
//   Combinational instruction classifier for the controller.
//   Ports:
//     opcode   in  6  instruction bits [31:26]
//     funct    in  6  instruction bits [5:0]
//     cls      out    instruction class (CLS_INVALID for unknown op/funct)
//     r_alu_op out 3  ALU_Control for the EXEC_R state
//     ovf_chk  out 1  instruction traps on signed overflow (add, sub, addi)
module control_decoder
  import control_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_e cls,
  output logic [2:0]   r_alu_op,
  output logic         ovf_chk
);

  always_comb begin
    cls      = CLS_INVALID;
    r_alu_op = ALU_ADD;
    ovf_chk  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            cls      = CLS_R;
            r_alu_op = ALU_ADD;
            ovf_chk  = 1'b1;
          end
          FN_SUB: begin
            cls      = CLS_R;
            r_alu_op = ALU_SUB;
            ovf_chk  = 1'b1;
          end
          FN_AND: begin
            cls      = CLS_R;
            r_alu_op = ALU_AND;
          end
          default: cls = CLS_INVALID;
        endcase
      end
      OP_ADDI: begin
        cls     = CLS_ADDI;
        ovf_chk = 1'b1;
      end
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_J:    cls = CLS_J;
      default: cls = CLS_INVALID;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit
//   Multicycle FSM controller driving the datapath write enables, mux
//   selects and ALU op, one state per cycle. Outputs are registered from
//   the next state; PCWrite additionally takes the EQ flag in BRANCH.
//   Build option: CONTROL_UNIT_EXCEPTIONS_EN adds the EXC state (overflow
//   trap, invalid opcode) and EPCWrite; without it EPCWrite is 0,
//   overflow is ignored and invalid opcodes act as NOPs.
//   Parameters: MEM_WAIT (1..7) memory latency in cycles; EXC_VECTOR, the
//   PC loaded on an exception (consumed by the datapath PC mux).
//   Ports:
//     clock, reset (sync, active-low)
//     OPCODE, FUNCT          decoded instruction fields
//     overflow, ZR, EQ       ALU flags
//     PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutWrite, EPCWrite
//     IorD, ALUSrcA, ALUSrcB, PCSource, RegDst, DataSrc, ALU_Control
module control_unit
  import control_pkg::*;
#(
  parameter int          MEM_WAIT   = 2,
  parameter logic [31:0] EXC_VECTOR = 32'h000000FF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       overflow,
  input  logic       ZR,
  input  logic       EQ,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ABWrite,
  output logic       ALUOutWrite,
  output logic       EPCWrite,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] RegDst,
  output logic [1:0] DataSrc,
  output logic [2:0] ALU_Control
);

  localparam logic [2:0] LAST_CNT = 3'(MEM_WAIT - 1);

  state_e       state, state_nxt;
  logic [2:0]   wait_cnt, wait_cnt_nxt;
  ctrl_t        ctrl_q, ctrl_nxt;
  instr_class_e cls;
  logic [2:0]   r_alu_op;
  logic         ovf_chk;
  logic         wait_done;
  logic         br_take;
  logic         unused_ok;

  control_decoder u_decoder (
    .opcode   (OPCODE),
    .funct    (FUNCT),
    .cls      (cls),
    .r_alu_op (r_alu_op),
    .ovf_chk  (ovf_chk)
  );

  assign wait_done = (wait_cnt == LAST_CNT);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:    state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = wait_done ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (cls)
          CLS_R:            state_nxt = ST_EXEC_R;
          CLS_ADDI:         state_nxt = ST_EXEC_I;
          CLS_LW, CLS_SW:   state_nxt = ST_ADDR;
          CLS_BEQ, CLS_BNE: state_nxt = ST_BRANCH;
          CLS_J:            state_nxt = ST_JUMP;
`ifdef CONTROL_UNIT_EXCEPTIONS_EN
          default:          state_nxt = ST_EXC;
`else
          default:          state_nxt = ST_FETCH;
`endif
        endcase
      end
`ifdef CONTROL_UNIT_EXCEPTIONS_EN
      // 'and' never traps, so overflow only counts when ovf_chk is set.
      ST_EXEC_R: state_nxt = (overflow && ovf_chk) ? ST_EXC : ST_WB_R;
      ST_EXEC_I: state_nxt = overflow ? ST_EXC : ST_WB_I;
`else
      ST_EXEC_R: state_nxt = ST_WB_R;
      ST_EXEC_I: state_nxt = ST_WB_I;
`endif
      ST_ADDR:   state_nxt = (cls == CLS_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: state_nxt = wait_done ? ST_WB_LW : ST_MEM_RD;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  // The counter only advances while a wait state repeats, so any entry
  // into FETCH or MEM_RD starts from 0 and it stops at LAST_CNT.
  always_comb begin
    wait_cnt_nxt = 3'd0;
    if (state_nxt == state && (state == ST_FETCH || state == ST_MEM_RD))
      wait_cnt_nxt = wait_cnt + 3'd1;
  end

  assign ctrl_nxt = ctrl_for(state_nxt, (wait_cnt_nxt == LAST_CNT), r_alu_op);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_RST;
      wait_cnt <= 3'd0;
      ctrl_q   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      ctrl_q   <= ctrl_nxt;
    end
  end

  // Branch decision uses the live EQ flag, so it cannot be registered.
  assign br_take = (state == ST_BRANCH) && ((cls == CLS_BEQ) ? EQ : !EQ);

  assign PCWrite     = ctrl_q.pc_write | br_take;
  assign MemWrite    = ctrl_q.mem_write;
  assign IRWrite     = ctrl_q.ir_write;
  assign RegWrite    = ctrl_q.reg_write;
  assign ABWrite     = ctrl_q.ab_write;
  assign ALUOutWrite = ctrl_q.alu_out_write;
`ifdef CONTROL_UNIT_EXCEPTIONS_EN
  assign EPCWrite    = ctrl_q.epc_write;
`else
  assign EPCWrite    = 1'b0;
`endif
  assign IorD        = ctrl_q.iord;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign PCSource    = ctrl_q.pc_source;
  assign RegDst      = ctrl_q.reg_dst;
  assign DataSrc     = ctrl_q.data_src;
  assign ALU_Control = ctrl_q.alu_ctrl;

  // ZR has no consumer here; EXC_VECTOR is applied by the datapath PC mux
  // and is kept on this block so both share one parameterisation.
  assign unused_ok = ^{ZR, overflow, ovf_chk, EXC_VECTOR};

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] OPCODE;
  logic [5:0] FUNCT;
  logic       overflow, ZR, EQ;
  logic       PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutWrite, EPCWrite;
  logic       IorD, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource, RegDst, DataSrc;
  logic [2:0] ALU_Control;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  control_unit #(.MEM_WAIT(2), .EXC_VECTOR(32'h000000FF)) dut (
    .clock(clock), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT),
    .overflow(overflow), .ZR(ZR), .EQ(EQ),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ABWrite(ABWrite), .ALUOutWrite(ALUOutWrite),
    .EPCWrite(EPCWrite), .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .RegDst(RegDst), .DataSrc(DataSrc),
    .ALU_Control(ALU_Control)
  );

  logic [19:0] obs;
  assign obs = {PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutWrite,
                EPCWrite, IorD, ALUSrcA, ALUSrcB, PCSource, RegDst, DataSrc,
                ALU_Control};

  function automatic logic [19:0] ev(
    input logic pcw, memw, irw, regw, abw, aluow, epcw, iord, srca,
    input logic [1:0] srcb, pcsrc, regdst, datasrc,
    input logic [2:0] alu);
    return {pcw, memw, irw, regw, abw, aluow, epcw, iord, srca,
            srcb, pcsrc, regdst, datasrc, alu};
  endfunction

  // Expected output vectors per state, taken from the state table.
  localparam logic [19:0] E_RST     = 20'h0;
  localparam logic [19:0] E_F       = ev(0,0,0,0,0,0,0,0,0, 2'b01,2'b00,2'b00,2'b00, 3'b001);
  localparam logic [19:0] E_FL      = ev(1,0,1,0,0,0,0,0,0, 2'b01,2'b00,2'b00,2'b00, 3'b001);
  localparam logic [19:0] E_DEC     = ev(0,0,0,0,1,1,0,0,0, 2'b11,2'b00,2'b00,2'b00, 3'b001);
  localparam logic [19:0] E_EXR_ADD = ev(0,0,0,0,0,1,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b001);
  localparam logic [19:0] E_EXR_SUB = ev(0,0,0,0,0,1,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b010);
  localparam logic [19:0] E_EXR_AND = ev(0,0,0,0,0,1,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b011);
  localparam logic [19:0] E_WBR     = ev(0,0,0,1,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00, 3'b000);
  localparam logic [19:0] E_EXI     = ev(0,0,0,0,0,1,0,0,1, 2'b10,2'b00,2'b00,2'b00, 3'b001);
  localparam logic [19:0] E_WBI     = ev(0,0,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000);
  localparam logic [19:0] E_MRD     = ev(0,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000);
  localparam logic [19:0] E_WBLW    = ev(0,0,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b01, 3'b000);
  localparam logic [19:0] E_MWR     = ev(0,1,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000);
  localparam logic [19:0] E_BR_T    = ev(1,0,0,0,0,0,0,0,1, 2'b00,2'b01,2'b00,2'b00, 3'b111);
  localparam logic [19:0] E_BR_N    = ev(0,0,0,0,0,0,0,0,1, 2'b00,2'b01,2'b00,2'b00, 3'b111);
  localparam logic [19:0] E_JMP     = ev(1,0,0,0,0,0,0,0,0, 2'b00,2'b11,2'b00,2'b00, 3'b000);
  localparam logic [19:0] E_EXC     = ev(1,0,0,0,0,0,1,0,0, 2'b01,2'b10,2'b00,2'b00, 3'b010);

  // Hold reset low for two edges, release at a falling edge; the next
  // rising edge enters FETCH (cycle 1).
  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [19:0] seq [$];
    OPCODE = 6'h00; FUNCT = 6'h20;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); @(negedge clock);
      checks++;
      if (obs !== E_RST) begin
        errors++;
        $display("FAIL reset_low cyc%0d: got %h expected %h", i, obs, E_RST);
      end
    end
    reset = 1'b1;
    seq = '{E_F, E_FL, E_DEC};
    foreach (seq[i]) begin
      @(posedge clock); @(negedge clock);
      checks++;
      if (obs !== seq[i]) begin
        errors++;
        $display("FAIL reset_release cyc%0d: got %h expected %h", i + 1, obs, seq[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0]  fn  [3];
    logic [19:0] exr [3];
    logic [19:0] seq [$];
    fn  = '{6'h20, 6'h22, 6'h24};
    exr = '{E_EXR_ADD, E_EXR_SUB, E_EXR_AND};
    for (int k = 0; k < 3; k++) begin
      OPCODE = 6'h00; FUNCT = fn[k]; overflow = 1'b0;
      apply_reset();
      seq = '{E_F, E_FL, E_DEC, exr[k], E_WBR, E_F};
      foreach (seq[i]) begin
        @(posedge clock); @(negedge clock);
        checks++;
        if (obs !== seq[i]) begin
          errors++;
          $display("FAIL rtype_f%h cyc%0d: got %h expected %h", fn[k], i + 1, obs, seq[i]);
        end
      end
    end
  endtask

  task automatic test_addi();
    logic [19:0] seq [$];
    OPCODE = 6'h08; FUNCT = 6'h3F; overflow = 1'b0;
    apply_reset();
    seq = '{E_F, E_FL, E_DEC, E_EXI, E_WBI, E_F};
    foreach (seq[i]) begin
      @(posedge clock); @(negedge clock);
      checks++;
      if (obs !== seq[i]) begin
        errors++;
        $display("FAIL addi cyc%0d: got %h expected %h", i + 1, obs, seq[i]);
      end
    end
  endtask

  task automatic test_lw();
    logic [19:0] seq [$];
    OPCODE = 6'h23; FUNCT = 6'h04; overflow = 1'b0;
    apply_reset();
    seq = '{E_F, E_FL, E_DEC, E_EXI, E_MRD, E_MRD, E_WBLW, E_F};
    foreach (seq[i]) begin
      @(posedge clock); @(negedge clock);
      checks++;
      if (obs !== seq[i]) begin
        errors++;
        $display("FAIL lw cyc%0d: got %h expected %h", i + 1, obs, seq[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [19:0] seq [$];
    OPCODE = 6'h2B; FUNCT = 6'h08; overflow = 1'b0;
    apply_reset();
    seq = '{E_F, E_FL, E_DEC, E_EXI, E_MWR, E_F, E_FL};
    foreach (seq[i]) begin
      @(posedge clock); @(negedge clock);
      checks++;
      if (obs !== seq[i]) begin
        errors++;
        $display("FAIL sw cyc%0d: got %h expected %h", i + 1, obs, seq[i]);
      end
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0]  op  [4];
    logic        eqv [4];
    logic [19:0] res [4];
    logic [19:0] seq [$];
    op  = '{6'h04, 6'h04, 6'h05, 6'h02};
    eqv = '{1'b1, 1'b0, 1'b0, 1'b1};
    res = '{E_BR_T, E_BR_N, E_BR_T, E_JMP};
    for (int k = 0; k < 4; k++) begin
      OPCODE = op[k]; FUNCT = 6'h00; EQ = eqv[k]; overflow = 1'b0;
      apply_reset();
      seq = '{E_F, E_FL, E_DEC, res[k], E_F};
      foreach (seq[i]) begin
        @(posedge clock); @(negedge clock);
        checks++;
        if (obs !== seq[i]) begin
          errors++;
          $display("FAIL branch_op%h_eq%0d cyc%0d: got %h expected %h",
                   op[k], eqv[k], i + 1, obs, seq[i]);
        end
      end
    end
    EQ = 1'b0;
  endtask

  task automatic test_exceptions();
    logic [19:0] seq [$];
    // add with overflow
    OPCODE = 6'h00; FUNCT = 6'h20; overflow = 1'b1;
    apply_reset();
`ifdef CONTROL_UNIT_EXCEPTIONS_EN
    seq = '{E_F, E_FL, E_DEC, E_EXR_ADD, E_EXC, E_F};
`else
    seq = '{E_F, E_FL, E_DEC, E_EXR_ADD, E_WBR, E_F};
`endif
    foreach (seq[i]) begin
      @(posedge clock); @(negedge clock);
      checks++;
      if (obs !== seq[i]) begin
        errors++;
        $display("FAIL ovf_add cyc%0d: got %h expected %h", i + 1, obs, seq[i]);
      end
    end
    // and never traps, even with overflow high
    FUNCT = 6'h24;
    apply_reset();
    seq = '{E_F, E_FL, E_DEC, E_EXR_AND, E_WBR};
    foreach (seq[i]) begin
      @(posedge clock); @(negedge clock);
      checks++;
      if (obs !== seq[i]) begin
        errors++;
        $display("FAIL ovf_and cyc%0d: got %h expected %h", i + 1, obs, seq[i]);
      end
    end
    // invalid opcode
    OPCODE = 6'h3F; FUNCT = 6'h00; overflow = 1'b0;
    apply_reset();
`ifdef CONTROL_UNIT_EXCEPTIONS_EN
    seq = '{E_F, E_FL, E_DEC, E_EXC, E_F};
`else
    seq = '{E_F, E_FL, E_DEC, E_F, E_FL};
`endif
    foreach (seq[i]) begin
      @(posedge clock); @(negedge clock);
      checks++;
      if (obs !== seq[i]) begin
        errors++;
        $display("FAIL invalid_op cyc%0d: got %h expected %h", i + 1, obs, seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid_memwr();
    logic [19:0] seq [$];
    OPCODE = 6'h2B; FUNCT = 6'h00; overflow = 1'b0;
    apply_reset();
    seq = '{E_F, E_FL, E_DEC, E_EXI, E_MWR};
    foreach (seq[i]) begin
      @(posedge clock); @(negedge clock);
      checks++;
      if (obs !== seq[i]) begin
        errors++;
        $display("FAIL memwr_pre cyc%0d: got %h expected %h", i + 1, obs, seq[i]);
      end
    end
    reset = 1'b0;
    @(posedge clock); @(negedge clock);
    checks++;
    if (obs !== E_RST) begin
      errors++;
      $display("FAIL memwr_reset: got %h expected %h", obs, E_RST);
    end
    reset = 1'b1;
    seq = '{E_F, E_FL, E_DEC};
    foreach (seq[i]) begin
      @(posedge clock); @(negedge clock);
      checks++;
      if (obs !== seq[i]) begin
        errors++;
        $display("FAIL memwr_after cyc%0d: got %h expected %h", i + 1, obs, seq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] seq [$];
    OPCODE = 6'h00; FUNCT = 6'h22; overflow = 1'b0;
    apply_reset();
    seq = '{E_F, E_FL, E_DEC, E_EXR_SUB, E_WBR};
    foreach (seq[i]) begin
      @(posedge clock); @(negedge clock);
      checks++;
      if (obs !== seq[i]) begin
        errors++;
        $display("FAIL b2b_sub cyc%0d: got %h expected %h", i + 1, obs, seq[i]);
      end
    end
    OPCODE = 6'h02;
    seq = '{E_F, E_FL, E_DEC, E_JMP, E_F};
    foreach (seq[i]) begin
      @(posedge clock); @(negedge clock);
      checks++;
      if (obs !== seq[i]) begin
        errors++;
        $display("FAIL b2b_j cyc%0d: got %h expected %h", i + 6, obs, seq[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b0; OPCODE = 6'h00; FUNCT = 6'h00;
    overflow = 1'b0; ZR = 1'b0; EQ = 1'b0;
    test_reset();
    test_rtype();
    test_addi();
    test_lw();
    test_sw();
    test_branch_jump();
    test_exceptions();
    test_reset_mid_memwr();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached after %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
